// File: rtl/aq_jpeg_enc_pkg.sv
// Shared types and byte constants for the JPEG encoder
// entropy-coded-segment bit packer.
package aq_jpeg_enc_pkg;

  typedef enum logic [2:0] {
    RUN,
    STUFF,
    PAD,
    MARK_FF,
    MARK_ID
  } state_t;

  localparam logic [7:0] MARKER_FF   = 8'hFF;
  localparam logic [7:0] MARKER_RST0 = 8'hD0;
  localparam logic [7:0] MARKER_EOI  = 8'hD9;
  localparam logic [7:0] STUFF_BYTE  = 8'h00;

endpackage

// File: rtl/aq_jpeg_enc_byte_out.sv
// One-entry output byte register with valid/ready hold
// and a flag that remembers a 0xFF data byte needs stuffing.
module aq_jpeg_enc_byte_out
  import aq_jpeg_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  input  logic       is_data,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] data,
  output logic       free,
  output logic       stuff_pend
);

  assign free = !valid || ready;

  // hold the byte until taken; a loaded data 0xFF arms stuffing
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      data       <= 8'h00;
      stuff_pend <= 1'b0;
    end else if (load) begin
      valid      <= 1'b1;
      data       <= byte_in;
      stuff_pend <= is_data && (byte_in == MARKER_FF);
    end else if (ready) begin
      valid      <= 1'b0;
    end
  end

endmodule

// File: rtl/aq_jpeg_hm_bitpack.sv
// Huffman code bit packer: MSB-first byte packing, 0xFF
// stuffing, 1-padding and RSTn/EOI marker insertion.
module aq_jpeg_hm_bitpack
  import aq_jpeg_enc_pkg::*;
#(
  parameter int MAX_CODE_WIDTH = 32,
  parameter int ACC_WIDTH      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ProcessInit,
  input  logic                      CodeInEnable,
  input  logic [5:0]                CodeInWidth,
  input  logic [MAX_CODE_WIDTH-1:0] CodeIn,
  output logic                      CodeInReady,
  input  logic                      CmdAlign,
  input  logic                      CmdRestart,
  input  logic [2:0]                CmdRstNum,
  input  logic                      CmdEoi,
  output logic                      CmdReady,
  output logic                      DataOutEnable,
  output logic [7:0]                DataOut,
  input  logic                      DataOutReady,
  output logic                      Idle
);

  localparam int CW = $clog2(ACC_WIDTH + 1);
  localparam logic [CW-1:0] CODE_LIMIT = CW'(ACC_WIDTH - MAX_CODE_WIDTH);
  localparam logic [CW-1:0] BYTE_W = CW'(8);

  state_t                    state, state_n;
  logic [ACC_WIDTH-1:0]      acc, acc_m, acc_n, add_bits;
  logic [CW-1:0]             cnt, cnt_m, cnt_n;
  logic [CW-1:0]             add_w, pad_w, code_w, sh;
  logic [MAX_CODE_WIDTH-1:0] code_mask;
  logic [7:0]                top_byte, load_byte;
  logic [2:0]                num_q;
  logic                      eoi_q, mark_q;
  logic                      cmd_any, code_acc, cmd_acc;
  logic                      load, load_data, free, stuff_pend, clear;

  assign clear       = rst || ProcessInit;
  assign cmd_any     = CmdAlign || CmdRestart || CmdEoi;
  assign CodeInReady = (state == RUN) && (cnt <= CODE_LIMIT);
  assign CmdReady    = (state == RUN) && !CodeInEnable;
  assign code_acc    = CodeInEnable && CodeInReady;
  assign cmd_acc     = cmd_any && CmdReady;
  assign Idle        = (state == RUN) && (cnt == '0) && !stuff_pend;

  assign code_w = (CW'(CodeInWidth) > CW'(MAX_CODE_WIDTH))
                ? CW'(MAX_CODE_WIDTH) : CW'(CodeInWidth);
  assign code_mask = ~({MAX_CODE_WIDTH{1'b1}} << code_w);
  assign pad_w = (cnt[2:0] == 3'd0)
               ? '0 : CW'(4'd8 - {1'b0, cnt[2:0]});
  assign top_byte = acc_m[ACC_WIDTH-1 -: 8];

  // append the accepted code or pad bits just below valid bits
  always_comb begin
    add_w    = '0;
    add_bits = '0;
    if (code_acc) begin
      add_w    = code_w;
      add_bits = ACC_WIDTH'(CodeIn & code_mask);
    end else if (cmd_acc) begin
      add_w    = pad_w;
      add_bits = ~({ACC_WIDTH{1'b1}} << pad_w);
    end
    sh    = CW'(ACC_WIDTH) - cnt - add_w;
    acc_m = acc | (add_bits << sh);
    cnt_m = cnt + add_w;
  end

  // byte emission and state sequencing
  always_comb begin
    state_n   = state;
    acc_n     = acc_m;
    cnt_n     = cnt_m;
    load      = 1'b0;
    load_byte = STUFF_BYTE;
    load_data = 1'b0;
    unique case (state)
      RUN: begin
        if (cmd_acc) state_n = PAD;
        if (free && cnt_m >= BYTE_W) begin
          load      = 1'b1;
          load_byte = top_byte;
          load_data = 1'b1;
          acc_n     = acc_m << 8;
          cnt_n     = cnt_m - BYTE_W;
          if (!cmd_acc && top_byte == MARKER_FF)
            state_n = STUFF;
        end
      end
      STUFF: begin
        if (free) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      PAD: begin
        if (free && stuff_pend) begin
          load = 1'b1;
        end else if (free && cnt >= BYTE_W) begin
          load      = 1'b1;
          load_byte = top_byte;
          load_data = 1'b1;
          acc_n     = acc_m << 8;
          cnt_n     = cnt_m - BYTE_W;
        end else if (cnt == '0 && !stuff_pend) begin
          state_n = mark_q ? MARK_FF : RUN;
        end
      end
      MARK_FF: begin
        if (free) begin
          load      = 1'b1;
          load_byte = MARKER_FF;
          state_n   = MARK_ID;
        end
      end
      MARK_ID: begin
        if (free) begin
          load      = 1'b1;
          load_byte = eoi_q ? MARKER_EOI
                            : (MARKER_RST0 | {5'b0, num_q});
          state_n   = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  // accumulator, state and latched command registers
  always_ff @(posedge clk) begin
    if (clear) begin
      state  <= RUN;
      acc    <= '0;
      cnt    <= '0;
      eoi_q  <= 1'b0;
      mark_q <= 1'b0;
      num_q  <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      if (cmd_acc) begin
        eoi_q  <= CmdEoi;
        mark_q <= CmdEoi || CmdRestart;
        num_q  <= CmdRstNum;
      end
    end
  end

  aq_jpeg_enc_byte_out u_byte_out (
    .clk        (clk),
    .rst        (clear),
    .load       (load),
    .byte_in    (load_byte),
    .is_data    (load_data),
    .ready      (DataOutReady),
    .valid      (DataOutEnable),
    .data       (DataOut),
    .free       (free),
    .stuff_pend (stuff_pend)
  );

endmodule
